// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - CPU-side request/response bundle for the data-memory controller
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  memop;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, memop, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, addr, memop, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte/half/word data-memory controller with split misaligned beats
module dmem_ctrl #(
    parameter int    ADDR_W      = 15,
    parameter bit    MISALIGN_EN = 1'b1,
    parameter string INIT_FILE   = ""
) (
    input  logic  clk,
    input  logic  rstn,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]       mem [2**ADDR_W];
    logic              we_q, cross_q, err_q;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        memop_q;
    logic [31:0]       wdata_q, lo_q, hi_q, rdata_q;

    logic        accept, ready, done;
    logic        wr0, wr1;
    logic [2:0]  size_in;
    logic        cross_in, illegal_in, bad_in;
    logic [ADDR_W-1:0] word0, word1;
    logic [63:0] lane, pair;
    logic [7:0]  mask;
    logic [31:0] sel, ext, result;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    // Request decode happens on the live bus so an error can skip the beats.
    always_comb begin
        case (bus.memop[1:0])
            2'b00:   size_in = 3'd1;
            2'b01:   size_in = 3'd2;
            default: size_in = 3'd4;
        endcase
        cross_in = ({1'b0, bus.addr[1:0]} + size_in) > 3'd4;
        if (bus.we)
            illegal_in = !(bus.memop inside {3'b000, 3'b001, 3'b010});
        else
            illegal_in = bus.memop inside {3'b011, 3'b110, 3'b111};
        bad_in = illegal_in || (cross_in && !MISALIGN_EN);
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.req) state_nxt = bad_in ? RESP : BEAT0;
            BEAT0: state_nxt = cross_q ? BEAT1 : RESP;
            BEAT1: state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE) && rstn;
        done   = (state == RESP);
        accept = ready && bus.req;
        wr0    = (state == BEAT0) && we_q && rstn;
        wr1    = (state == BEAT1) && we_q && rstn;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            memop_q <= 3'b000;
            wdata_q <= '0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr[ADDR_W+1:0];
            memop_q <= bus.memop;
            wdata_q <= bus.wdata;
            cross_q <= cross_in;
            err_q   <= bad_in;
        end
    end

    // Second beat wraps naturally through the ADDR_W-bit increment.
    assign word0 = addr_q[ADDR_W+1:2];
    assign word1 = word0 + 1'b1;
    assign lane  = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};

    always_comb begin
        case (memop_q[1:0])
            2'b00:   mask = 8'h01 << addr_q[1:0];
            2'b01:   mask = 8'h03 << addr_q[1:0];
            default: mask = 8'h0F << addr_q[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr0 && mask[b])   mem[word0][8*b +: 8] <= lane[8*b +: 8];
            if (wr1 && mask[b+4]) mem[word1][8*b +: 8] <= lane[32+8*b +: 8];
        end
        if (state == BEAT0) lo_q <= mem[word0];
        if (state == BEAT1) hi_q <= mem[word1];
    end

    always_comb begin
        pair = {cross_q ? hi_q : 32'b0, lo_q} >> {addr_q[1:0], 3'b000};
        sel  = pair[31:0];
        case (memop_q)
            3'b000:  ext = {{24{sel[7]}}, sel[7:0]};
            3'b001:  ext = {{16{sel[15]}}, sel[15:0]};
            3'b100:  ext = {24'b0, sel[7:0]};
            3'b101:  ext = {16'b0, sel[15:0]};
            default: ext = sel;
        endcase
        result = (we_q || err_q) ? 32'b0 : ext;
    end

    // The freshly read word only lands in lo_q/hi_q at the RESP edge, so the
    // done cycle forwards it and the holding register keeps it afterwards.
    always_ff @(posedge clk) begin
        if (!rstn)              rdata_q <= '0;
        else if (state == RESP) rdata_q <= result;
    end

    assign bus.ready = ready;
    assign bus.done  = done;
    assign bus.err   = done && err_q;
    assign bus.rdata = done ? result : rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dmem_if b0 ();
    dmem_if b1 ();
    dmem_if b2 ();

    dmem_ctrl #(.ADDR_W(15), .MISALIGN_EN(1'b1)) u_main (.clk(clk), .rstn(rstn), .bus(b0.slave));
    dmem_ctrl #(.ADDR_W(4),  .MISALIGN_EN(1'b1)) u_wrap (.clk(clk), .rstn(rstn), .bus(b1.slave));
    dmem_ctrl #(.ADDR_W(4),  .MISALIGN_EN(1'b0)) u_noms (.clk(clk), .rstn(rstn), .bus(b2.slave));

    logic        req_v [3];
    logic        we_v  [3];
    logic [31:0] addr_v[3];
    logic [2:0]  op_v  [3];
    logic [31:0] wd_v  [3];
    logic        rdy_v [3];
    logic        done_v[3];
    logic        err_v [3];
    logic [31:0] rd_v  [3];

    assign b0.req = req_v[0]; assign b0.we = we_v[0]; assign b0.addr = addr_v[0];
    assign b0.memop = op_v[0]; assign b0.wdata = wd_v[0];
    assign b1.req = req_v[1]; assign b1.we = we_v[1]; assign b1.addr = addr_v[1];
    assign b1.memop = op_v[1]; assign b1.wdata = wd_v[1];
    assign b2.req = req_v[2]; assign b2.we = we_v[2]; assign b2.addr = addr_v[2];
    assign b2.memop = op_v[2]; assign b2.wdata = wd_v[2];
    assign rdy_v[0] = b0.ready; assign done_v[0] = b0.done; assign err_v[0] = b0.err; assign rd_v[0] = b0.rdata;
    assign rdy_v[1] = b1.ready; assign done_v[1] = b1.done; assign err_v[1] = b1.err; assign rd_v[1] = b1.rdata;
    assign rdy_v[2] = b2.ready; assign done_v[2] = b2.done; assign err_v[2] = b2.err; assign rd_v[2] = b2.rdata;

    // One transaction on DUT s; lat counts cycles from accept edge to done (99 = none).
    task automatic access(input int s, input logic w, input logic [31:0] a, input logic [2:0] op,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
        int waits;
        rd = 32'hx; e = 1'bx; lat = 99;
        @(negedge clk);
        waits = 0;
        while (!rdy_v[s] && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!rdy_v[s]) begin
            $display("FAIL ready_timeout dut=%0d ready=%b required 1", s, rdy_v[s]);
            miscompares++;
            vectors++;
            return;
        end
        req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; op_v[s] = op; wd_v[s] = wd;
        @(posedge clk);
        #1 req_v[s] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done_v[s]) begin
                lat = k; rd = rd_v[s]; e = err_v[s];
                break;
            end
        end
    endtask

    task automatic load_check(input int s, input string name, input logic [31:0] a,
                              input logic [2:0] op, input logic [31:0] exp_rd, input int exp_lat);
        logic [31:0] rd; logic e; int lat;
        access(s, 1'b0, a, op, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== exp_rd || e !== 1'b0 || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s got rdata=%h err=%b lat=%0d required rdata=%h err=0 lat=%0d",
                     name, rd, e, lat, exp_rd, exp_lat);
        end
    endtask

    task automatic store_check(input int s, input string name, input logic [31:0] a,
                               input logic [2:0] op, input logic [31:0] wd, input int exp_lat);
        logic [31:0] rd; logic e; int lat;
        access(s, 1'b1, a, op, wd, rd, e, lat);
        vectors++;
        if (rd !== 32'h0 || e !== 1'b0 || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s got rdata=%h err=%b lat=%0d required rdata=0 err=0 lat=%0d",
                     name, rd, e, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rdy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[0] !== 1'b0 || rd_v[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b done=%b err=%b rdata=%h required 0 0 0 0",
                     rdy_v[0], done_v[0], err_v[0], rd_v[0]);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b required 1", rdy_v[0]);
        end
    endtask

    task automatic test_aligned();
        store_check(0, "sw_0x10", 32'h10, 3'b010, 32'hDEADBEEF, 2);
        load_check(0, "lw_0x10", 32'h10, 3'b010, 32'hDEADBEEF, 2);
    endtask

    task automatic test_back_to_back();
        load_check(0, "b2b_lw_first", 32'h10, 3'b010, 32'hDEADBEEF, 2);
        @(negedge clk);
        vectors++;
        if (rdy_v[0] !== 1'b1 || rd_v[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_ready_hold got ready=%b rdata=%h required 1 deadbeef", rdy_v[0], rd_v[0]);
        end
        load_check(0, "b2b_lbu", 32'h10, 3'b100, 32'h000000EF, 2);
    endtask

    task automatic test_subword();
        load_check(0, "lb_0x11",  32'h11, 3'b000, 32'hFFFFFFBE, 2);
        load_check(0, "lbu_0x11", 32'h11, 3'b100, 32'h000000BE, 2);
        load_check(0, "lh_0x12",  32'h12, 3'b001, 32'hFFFFDEAD, 2);
        load_check(0, "lhu_0x12", 32'h12, 3'b101, 32'h0000DEAD, 2);
    endtask

    task automatic test_cross();
        store_check(0, "clr_0x10", 32'h10, 3'b010, 32'h0, 2);
        store_check(0, "clr_0x14", 32'h14, 3'b010, 32'h0, 2);
        store_check(0, "sw_cross_0x13", 32'h13, 3'b010, 32'h11223344, 3);
        load_check(0, "cross_word_0x10", 32'h10, 3'b010, 32'h44000000, 2);
        load_check(0, "cross_word_0x14", 32'h14, 3'b010, 32'h00112233, 2);
        load_check(0, "lw_cross_0x13", 32'h13, 3'b010, 32'h11223344, 3);
        load_check(0, "lh_cross_0x13", 32'h13, 3'b001, 32'h00003344, 2 + 1);
    endtask

    task automatic test_wrap();
        store_check(1, "wrap_clr_w15", 32'h3C, 3'b010, 32'h0, 2);
        store_check(1, "wrap_clr_w0",  32'h00, 3'b010, 32'h0, 2);
        store_check(1, "sh_wrap_0x3f", 32'h3F, 3'b001, 32'h0000ABCD, 3);
        load_check(1, "wrap_word15", 32'h3C, 3'b010, 32'hCD000000, 2);
        load_check(1, "wrap_word0",  32'h00, 3'b010, 32'h000000AB, 2);
        load_check(1, "lhu_wrap_0x3f", 32'h3F, 3'b101, 32'h0000ABCD, 3);
        load_check(1, "lh_wrap_0x3f",  32'h3F, 3'b001, 32'hFFFFABCD, 3);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        access(0, 1'b0, 32'h10, 3'b011, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'h0 || e !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL illegal_load got rdata=%h err=%b lat=%0d required 0 1 1", rd, e, lat);
        end
        access(0, 1'b1, 32'h10, 3'b100, 32'hFFFFFFFF, rd, e, lat);
        vectors++;
        if (rd !== 32'h0 || e !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL illegal_store got rdata=%h err=%b lat=%0d required 0 1 1", rd, e, lat);
        end
        load_check(0, "ram_after_errors", 32'h10, 3'b010, 32'h44000000, 2);
        store_check(2, "noms_sw_0x10", 32'h10, 3'b010, 32'h12345678, 2);
        access(2, 1'b0, 32'h13, 3'b010, 32'h0, rd, e, lat);
        vectors++;
        if (rd !== 32'h0 || e !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL noms_lw_0x13 got rdata=%h err=%b lat=%0d required 0 1 1", rd, e, lat);
        end
        access(2, 1'b1, 32'h13, 3'b001, 32'hFFFF, rd, e, lat);
        vectors++;
        if (e !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL noms_sh_0x13 got err=%b lat=%0d required 1 1", e, lat);
        end
        load_check(2, "noms_ram_kept", 32'h10, 3'b010, 32'h12345678, 2);
        load_check(2, "noms_aligned_lh", 32'h12, 3'b001, 32'h00001234, 2);
    endtask

    task automatic test_reset_midop();
        int done_seen;
        store_check(0, "mid_clr_0x18", 32'h18, 3'b010, 32'h0, 2);
        store_check(0, "mid_clr_0x1c", 32'h1C, 3'b010, 32'h0, 2);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h1B; op_v[0] = 3'b010; wd_v[0] = 32'hA1B2C3D4;
        @(posedge clk);
        #1 req_v[0] = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        vectors++;
        if (done_seen !== 0 || rdy_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset got done_count=%0d ready=%b required 0 0", done_seen, rdy_v[0]);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_release got ready=%b done=%b required 1 0", rdy_v[0], done_v[0]);
        end
        load_check(0, "midop_word_a",  32'h18, 3'b010, 32'hD4000000, 2);
        load_check(0, "midop_word_a1", 32'h1C, 3'b010, 32'h00000000, 2);
        load_check(0, "midop_after", 32'h13, 3'b010, 32'h11223344, 3);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; op_v[i] = 3'b010; wd_v[i] = '0;
        end
        test_reset();
        test_aligned();
        test_back_to_back();
        test_subword();
        test_cross();
        test_wrap();
        test_errors();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1);
    end
endmodule
